mux_rr_arbiter: RTL and testbench

- Shares one 2:1 output channel (z) between two requesters, A and B, using round-robin with a bounded hold.
- Drives `sel` with the select convention of the team's 2:1 mux: sel=0 passes A, sel=1 passes B.
- Each requester and the consumer use a valid/ready handshake.
- The output is registered, giving one cycle of latency from an accepted transfer to z.

---
 rtl/mux_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 output channel between
// requesters A and B, with a bounded hold per owner while the other waits.
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             z_valid,
    output logic [WIDTH-1:0] z_data,
    input  logic             z_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic [CW-1:0]    count_inc_s;
    logic             last_b_r;
    logic             sel_r;
    logic             sel_s;
    logic             z_valid_r;
    logic [WIDTH-1:0] z_data_r;
    logic             space_s;
    logic             xfer_a_s;
    logic             xfer_b_s;

    // Space exists when the output register is empty or draining this cycle.
    assign space_s  = ~z_valid_r | z_ready;
    assign a_ready  = (state_r == OWN_A) & space_s;
    assign b_ready  = (state_r == OWN_B) & space_s;
    assign xfer_a_s = a_valid & a_ready;
    assign xfer_b_s = b_valid & b_ready;

    assign z_valid  = z_valid_r;
    assign z_data   = z_data_r;
    assign sel      = sel_r;
    assign busy     = (state_r != IDLE);

    // Next-state and hold-count logic for the ownership FSM.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        count_inc_s = count_r + COUNT_ONE;
        case (state_r)
            IDLE: begin
                count_s = COUNT_ZERO;
                if (a_valid & b_valid) begin
                    state_s = last_b_r ? OWN_A : OWN_B;
                end else if (a_valid) begin
                    state_s = OWN_A;
                end else if (b_valid) begin
                    state_s = OWN_B;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN_A: begin
                if (xfer_a_s) begin
                    if (count_inc_s == HOLD_LIMIT) begin
                        count_s = COUNT_ZERO;
                        state_s = b_valid ? OWN_B : OWN_A;
                    end else begin
                        count_s = count_inc_s;
                        state_s = OWN_A;
                    end
                end else if (a_valid) begin
                    // Stalled by the consumer: keep ownership and the count.
                    count_s = count_r;
                    state_s = OWN_A;
                end else begin
                    count_s = COUNT_ZERO;
                    state_s = b_valid ? OWN_B : IDLE;
                end
            end
            OWN_B: begin
                if (xfer_b_s) begin
                    if (count_inc_s == HOLD_LIMIT) begin
                        count_s = COUNT_ZERO;
                        state_s = a_valid ? OWN_A : OWN_B;
                    end else begin
                        count_s = count_inc_s;
                        state_s = OWN_B;
                    end
                end else if (b_valid) begin
                    count_s = count_r;
                    state_s = OWN_B;
                end else begin
                    count_s = COUNT_ZERO;
                    state_s = a_valid ? OWN_A : IDLE;
                end
            end
            default: begin
                count_s = COUNT_ZERO;
                state_s = IDLE;
            end
        endcase
    end

    // Select follows the next owner and keeps its last value while idle.
    always_comb begin
        sel_s = sel_r;
        case (state_s)
            OWN_A:   sel_s = 1'b0;
            OWN_B:   sel_s = 1'b1;
            default: sel_s = sel_r;
        endcase
    end

    // Ownership state, hold count, select and last-served registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= COUNT_ZERO;
            sel_r    <= 1'b0;
            last_b_r <= 1'b1;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            sel_r   <= sel_s;
            if (xfer_a_s) begin
                last_b_r <= 1'b0;
            end else if (xfer_b_s) begin
                last_b_r <= 1'b1;
            end else begin
                last_b_r <= last_b_r;
            end
        end
    end

    // Output register: load on a transfer, clear on drain, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_valid_r <= 1'b0;
            z_data_r  <= {WIDTH{1'b0}};
        end else if (xfer_a_s) begin
            z_valid_r <= 1'b1;
            z_data_r  <= a_data;
        end else if (xfer_b_s) begin
            z_valid_r <= 1'b1;
            z_data_r  <= b_data;
        end else if (z_ready) begin
            z_valid_r <= 1'b0;
            z_data_r  <= z_data_r;
        end else begin
            z_valid_r <= z_valid_r;
            z_data_r  <= z_data_r;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model and order scoreboard.
module tb_mux_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             z_valid;
    logic [WIDTH-1:0] z_data;
    logic             z_ready = 1'b1;
    logic             sel;
    logic             busy;

    int checks = 0;
    int failures = 0;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .z_valid(z_valid), .z_data(z_data), .z_ready(z_ready),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = 8'h00; b_data = 8'h00; z_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        b_valid = 1'b1; b_data = 8'h5A; z_ready = 1'b0; #1;
        tick();
        tick();
        checks++; if (z_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_zvalid got=%b exp=1", z_valid); end
        checks++; if (z_data !== 8'h5A) begin failures++; $display("FAIL rst_pre_zdata got=%h exp=5a", z_data); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL rst_pre_sel got=%b exp=1", sel); end
        #2; reset = 1'b1; #1;
        checks++; if (z_valid !== 1'b0) begin failures++; $display("FAIL rst_zvalid got=%b exp=0", z_valid); end
        checks++; if (z_data !== 8'h00) begin failures++; $display("FAIL rst_zdata got=%h exp=00", z_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rst_sel got=%b exp=0", sel); end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rst_bready got=%b exp=0", b_ready); end
        b_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_a_only();
        do_reset();
        a_valid = 1'b1; a_data = 8'h11; #1;
        checks++; if (busy !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL aonly_c0 busy=%b a_ready=%b exp=0,0", busy, a_ready); end
        tick();
        checks++; if (busy !== 1'b1 || sel !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL aonly_c1 busy=%b sel=%b a_ready=%b exp=1,0,1", busy, sel, a_ready); end
        tick(); a_data = 8'h22; #1;
        checks++; if (a_ready !== 1'b1 || z_valid !== 1'b1 || z_data !== 8'h11) begin failures++; $display("FAIL aonly_c2 a_ready=%b z=%b/%h exp=1,1/11", a_ready, z_valid, z_data); end
        tick(); a_data = 8'h33; #1;
        checks++; if (a_ready !== 1'b1 || z_data !== 8'h22 || sel !== 1'b0) begin failures++; $display("FAIL aonly_c3 a_ready=%b z=%h sel=%b exp=1,22,0", a_ready, z_data, sel); end
        tick(); a_valid = 1'b0; #1;
        checks++; if (z_valid !== 1'b1 || z_data !== 8'h33 || sel !== 1'b0) begin failures++; $display("FAIL aonly_c4 z=%b/%h sel=%b exp=1/33,0", z_valid, z_data, sel); end
        tick(); #1;
        checks++; if (busy !== 1'b0 || z_valid !== 1'b0) begin failures++; $display("FAIL aonly_c5 busy=%b z_valid=%b exp=0,0", busy, z_valid); end
    endtask

    task automatic test_round_robin();
        int na = 0;
        int nb = 0;
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0; #1;
        for (int k = 1; k <= 20; k++) begin
            int t;
            int own;
            tick();
            a_data = 8'hA0 + 8'(na); b_data = 8'hB0 + 8'(nb); #1;
            t = k - 1;
            own = (t / MAX_HOLD) % 2;
            checks++; if (sel !== 1'(own) || a_ready !== (own == 0) || b_ready !== (own == 1)) begin failures++; $display("FAIL rr_owner cyc=%0d sel=%b a_ready=%b b_ready=%b exp_sel=%0d", k, sel, a_ready, b_ready, own); end
            if (k >= 2) begin
                int t2;
                int blk;
                int idx;
                logic [7:0] exp_d;
                t2 = k - 2;
                blk = t2 / MAX_HOLD;
                idx = (blk / 2) * MAX_HOLD + t2 % MAX_HOLD;
                exp_d = ((blk % 2) == 0) ? 8'hA0 + 8'(idx) : 8'hB0 + 8'(idx);
                checks++; if (z_valid !== 1'b1 || z_data !== exp_d) begin failures++; $display("FAIL rr_z cyc=%0d got=%b/%h exp=1/%h", k, z_valid, z_data, exp_d); end
            end
            if (a_ready && a_valid) na++;
            if (b_ready && b_valid) nb++;
        end
    endtask

    task automatic test_tie_after_b();
        do_reset();
        b_valid = 1'b1; b_data = 8'h77; #1;
        tick();
        tick(); b_valid = 1'b0; #1;
        tick(); a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h12; b_data = 8'h34; #1;
        checks++; if (busy !== 1'b0 || sel !== 1'b1) begin failures++; $display("FAIL tie_idle busy=%b sel=%b exp=0,1", busy, sel); end
        tick(); #1;
        checks++; if (sel !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL tie_grant sel=%b a_ready=%b b_ready=%b exp=0,1,0", sel, a_ready, b_ready); end
        tick(); #1;
        checks++; if (z_data !== 8'h12) begin failures++; $display("FAIL tie_z got=%h exp=12", z_data); end
    endtask

    task automatic test_stall();
        int na = 0;
        do_reset();
        a_valid = 1'b1; a_data = 8'hC0; z_ready = 1'b0; #1;
        tick(); #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL stall_first got=%b exp=1", a_ready); end
        na = 1;
        tick(); a_data = 8'hC1; b_valid = 1'b1; b_data = 8'hD0; #1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin tick(); #1; end
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || z_valid !== 1'b1 || z_data !== 8'hC0 || sel !== 1'b0) begin
                failures++; $display("FAIL stall_hold s=%0d a_ready=%b b_ready=%b z=%b/%h sel=%b exp=0,0,1/c0,0", s, a_ready, b_ready, z_valid, z_data, sel);
            end
        end
        tick(); z_ready = 1'b1; #1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin tick(); a_data = 8'hC0 + 8'(na); #1; end
            checks++; if (sel !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL stall_resume s=%0d sel=%b a_ready=%b exp=0,1", s, sel, a_ready); end
            na++;
        end
        tick(); #1;
        checks++; if (sel !== 1'b1 || b_ready !== 1'b1 || z_data !== 8'hC3) begin failures++; $display("FAIL stall_switch sel=%b b_ready=%b z=%h exp=1,1,c3", sel, b_ready, z_data); end
    endtask

    task automatic test_switch_on_drop();
        int nb = 0;
        do_reset();
        a_valid = 1'b1; a_data = 8'hE0; #1;
        tick(); #1;
        tick(); a_data = 8'hE1; b_valid = 1'b1; b_data = 8'hF0; #1;
        checks++; if (a_ready !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL drop_c2 a_ready=%b sel=%b exp=1,0", a_ready, sel); end
        tick(); a_valid = 1'b0; #1;
        checks++; if (sel !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL drop_c3 sel=%b b_ready=%b exp=0,0", sel, b_ready); end
        tick(); a_valid = 1'b1; a_data = 8'hE2; #1;
        for (int k = 4; k <= 7; k++) begin
            if (k > 4) begin tick(); b_data = 8'hF0 + 8'(nb); #1; end
            checks++; if (sel !== 1'b1 || b_ready !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL drop_own_b cyc=%0d sel=%b b_ready=%b a_ready=%b exp=1,1,0", k, sel, b_ready, a_ready); end
            if (k >= 5) begin
                checks++; if (z_data !== 8'hF0 + 8'(k - 5)) begin failures++; $display("FAIL drop_z cyc=%0d got=%h exp=%h", k, z_data, 8'hF0 + 8'(k - 5)); end
            end
            nb++;
        end
        tick(); #1;
        checks++; if (sel !== 1'b0 || a_ready !== 1'b1 || z_data !== 8'hF3) begin failures++; $display("FAIL drop_back sel=%b a_ready=%b z=%h exp=0,1,f3", sel, a_ready, z_data); end
    endtask

    task automatic test_random();
        bit         v[1:2];
        bit         acc[1:2];
        bit         r[1:2];
        logic [7:0] d[1:2];
        logic [7:0] q[$];
        int         m_own = 0;
        int         m_sel = 0;
        int         m_cnt = 0;
        int         m_last = 2;
        bit         m_zv = 1'b0;
        logic [7:0] m_zd = 8'h00;
        bit         zr;
        bit         space;
        int         nxt;
        v[1] = 1'b0; v[2] = 1'b0; acc[1] = 1'b0; acc[2] = 1'b0;
        d[1] = 8'h00; d[2] = 8'h00;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) tick();
            for (int i = 1; i <= 2; i++) begin
                if (!(v[i] && !acc[i])) begin
                    v[i] = ($urandom_range(0, 99) < 55);
                    d[i] = 8'($urandom);
                end
            end
            zr = ($urandom_range(0, 99) < 65);
            a_valid = v[1]; a_data = d[1]; b_valid = v[2]; b_data = d[2]; z_ready = zr; #1;
            space = !m_zv || zr;
            r[1] = (m_own == 1) && space;
            r[2] = (m_own == 2) && space;
            checks++; if (a_ready !== r[1] || b_ready !== r[2]) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", c, a_ready, b_ready, r[1], r[2]); end
            checks++; if (sel !== 1'(m_sel) || busy !== (m_own != 0)) begin failures++; $display("FAIL rnd_sel_busy cyc=%0d got=%b%b exp=%0d%0d", c, sel, busy, m_sel, m_own != 0); end
            checks++; if (z_valid !== m_zv || (m_zv && z_data !== m_zd)) begin failures++; $display("FAIL rnd_z cyc=%0d got=%b/%h exp=%b/%h", c, z_valid, z_data, m_zv, m_zd); end
            if (z_valid && zr) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rnd_order cyc=%0d got=%h exp=none", c, z_data); end
                else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    if (z_data !== e) begin failures++; $display("FAIL rnd_order cyc=%0d got=%h exp=%h", c, z_data, e); end
                end
            end
            acc[1] = v[1] && r[1];
            acc[2] = v[2] && r[2];
            nxt = m_own;
            if (m_own != 0 && acc[m_own]) begin
                q.push_back(d[m_own]); m_zd = d[m_own]; m_zv = 1'b1; m_last = m_own;
            end else if (zr) begin
                m_zv = 1'b0;
            end
            if (m_own == 0) begin
                m_cnt = 0;
                if (v[1] && v[2]) nxt = (m_last == 2) ? 1 : 2;
                else if (v[1]) nxt = 1;
                else if (v[2]) nxt = 2;
                else nxt = 0;
            end else begin
                int y;
                y = 3 - m_own;
                if (acc[m_own]) begin
                    m_cnt++;
                    if (m_cnt == MAX_HOLD) begin
                        m_cnt = 0;
                        if (v[y]) nxt = y;
                    end
                end else if (!v[m_own]) begin
                    m_cnt = 0;
                    nxt = v[y] ? y : 0;
                end
            end
            m_own = nxt;
            if (nxt != 0) m_sel = nxt - 1;
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_round_robin();
        test_tie_after_b();
        test_stall();
        test_switch_on_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
